// File: rtl/frame_deframer_rx_if.sv
// Bit-stream input and byte/status output bundle of the receive deframer.
// The bit-recovery side drives the master modport, the deframer is the slave.
interface frame_deframer_rx_if #(
   parameter int DATA_W = 8
);
   logic              bit_en;
   logic              bit_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              locked;
   logic [7:0]        good_cnt;
   logic [7:0]        err_cnt;

   modport master (
      output bit_en,
      output bit_in,
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  locked,
      input  good_cnt,
      input  err_cnt
   );

   modport slave (
      input  bit_en,
      input  bit_in,
      output data_out,
      output data_valid,
      output parity_err,
      output locked,
      output good_cnt,
      output err_cnt
   );
endinterface

// File: rtl/frame_deframer_rx.sv
// Receive deframer: hunts for the sync word in a strobed serial stream, collects an
// MSB-first payload, checks even parity and reports each frame with a 1-cycle strobe.
module frame_deframer_rx #(
   parameter int                DATA_W    = 8,
   parameter int                SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'b0111_1110,
   parameter bit                PARITY_EN = 1'b1
) (
   input logic               sysclk,
   input logic               reset,
   frame_deframer_rx_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      HUNT,
      DATA,
      PAR,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [SYNC_W-1:0] syncSr_q, syncSr_d;
   logic [DATA_W-1:0] dataSr_q, dataSr_d;
   logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
   logic              ok_q, ok_d;
   logic [DATA_W-1:0] dataOut_q, dataOut_d;
   logic              dataValid_q, dataValid_d;
   logic              parityErr_q, parityErr_d;
   logic              locked_q, locked_d;
   logic [7:0]        goodCnt_q, goodCnt_d;
   logic [7:0]        errCnt_q, errCnt_d;

   logic [SYNC_W-1:0] syncShift;
   logic              syncMatch;
   logic              lastDataBit;
   logic              frameOk;

   // The match test looks at the shift register including the bit being taken now.
   assign syncShift   = {syncSr_q[SYNC_W-2:0], bus.bit_in};
   assign syncMatch   = (syncShift == SYNC_WORD);
   assign lastDataBit = (bitCnt_q == CNT_W'(DATA_W - 1));
   assign frameOk     = PARITY_EN ? ok_q : 1'b1;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT: begin
            if (bus.bit_en && syncMatch) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bus.bit_en && lastDataBit) begin
               state_d = PARITY_EN ? PAR : DONE;
            end
         end
         PAR: begin
            if (bus.bit_en) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = HUNT;
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // DONE ignores bit_en entirely, so a strobe landing in that cycle is dropped.
   always_comb begin
      syncSr_d    = syncSr_q;
      dataSr_d    = dataSr_q;
      bitCnt_d    = bitCnt_q;
      ok_d        = ok_q;
      dataOut_d   = dataOut_q;
      dataValid_d = 1'b0;
      parityErr_d = 1'b0;
      locked_d    = locked_q;
      goodCnt_d   = goodCnt_q;
      errCnt_d    = errCnt_q;
      unique case (state_q)
         HUNT: begin
            if (bus.bit_en) begin
               syncSr_d = syncShift;
               if (syncMatch) begin
                  bitCnt_d = '0;
                  locked_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (bus.bit_en) begin
               dataSr_d = {dataSr_q[DATA_W-2:0], bus.bit_in};
               bitCnt_d = bitCnt_q + CNT_W'(1);
            end
         end
         PAR: begin
            if (bus.bit_en) begin
               ok_d = ~(^dataSr_q ^ bus.bit_in);
            end
         end
         DONE: begin
            dataOut_d = dataSr_q;
            locked_d  = 1'b0;
            syncSr_d  = '0;
            if (frameOk) begin
               dataValid_d = 1'b1;
               if (goodCnt_q != 8'hFF) begin
                  goodCnt_d = goodCnt_q + 8'd1;
               end
            end else begin
               parityErr_d = 1'b1;
               if (errCnt_q != 8'hFF) begin
                  errCnt_d = errCnt_q + 8'd1;
               end
            end
         end
         default: begin
            syncSr_d = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         syncSr_q    <= '0;
         dataSr_q    <= '0;
         bitCnt_q    <= '0;
         ok_q        <= 1'b0;
         dataOut_q   <= '0;
         dataValid_q <= 1'b0;
         parityErr_q <= 1'b0;
         locked_q    <= 1'b0;
         goodCnt_q   <= '0;
         errCnt_q    <= '0;
      end else begin
         syncSr_q    <= syncSr_d;
         dataSr_q    <= dataSr_d;
         bitCnt_q    <= bitCnt_d;
         ok_q        <= ok_d;
         dataOut_q   <= dataOut_d;
         dataValid_q <= dataValid_d;
         parityErr_q <= parityErr_d;
         locked_q    <= locked_d;
         goodCnt_q   <= goodCnt_d;
         errCnt_q    <= errCnt_d;
      end
   end

   assign bus.data_out   = dataOut_q;
   assign bus.data_valid = dataValid_q;
   assign bus.parity_err = parityErr_q;
   assign bus.locked     = locked_q;
   assign bus.good_cnt   = goodCnt_q;
   assign bus.err_cnt    = errCnt_q;

endmodule

// File: tb/tb_frame_deframer_rx.sv
// Randomised bench for frame_deframer_rx: a stream-level model decodes every bit sent
// since the last reset and the frames reported by the DUT are compared against it.
module tb_frame_deframer_rx;

   typedef struct {
      logic [7:0] data;
      bit         ok;
   } event_t;

   logic sysclk;
   logic reset;

   event_t obsQ[$];
   event_t expQ[$];
   bit     streamQ[$];
   int     checkedIdx;
   int     errors;
   int     checks;
   int     lockedCycles;
   int     injected;

   frame_deframer_rx_if #(.DATA_W(8)) bus ();

   frame_deframer_rx dut (
      .sysclk (sysclk),
      .reset  (reset),
      .bus    (bus)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Record every reported frame; the two strobes must never coincide.
   always @(negedge sysclk) begin
      if (!reset) begin
         if (bus.locked) lockedCycles++;
         if (bus.data_valid || bus.parity_err) begin
            event_t e;
            checkOutput("strobeExcl", 32'(bus.data_valid & bus.parity_err), 32'd0);
            e.data = bus.data_out;
            e.ok   = bus.data_valid;
            obsQ.push_back(e);
         end
      end
   end

   task automatic applyStimulus(input bit b, input int spacing);
      bus.bit_en = 1'b1;
      bus.bit_in = b;
      streamQ.push_back(b);
      @(posedge sysclk);
      #1;
      bus.bit_en = 1'b0;
      bus.bit_in = 1'($urandom);
      repeat (spacing - 1) @(posedge sysclk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] v, input int minGap, input int maxGap);
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(v[i], int'($urandom_range(maxGap, minGap)));
      end
   endtask

   task automatic sendFrame(input logic [7:0] d, input bit flip, input int minGap,
                            input int maxGap);
      sendByte(8'h7E, minGap, maxGap);
      sendByte(d, minGap, maxGap);
      applyStimulus((^d) ^ flip, int'($urandom_range(maxGap, minGap)));
   endtask

   task automatic doReset();
      reset      = 1'b1;
      bus.bit_en = 1'b0;
      bus.bit_in = 1'b0;
      obsQ.delete();
      streamQ.delete();
      expQ.delete();
      checkedIdx = 0;
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b0;
      @(posedge sysclk);
      #1;
   endtask

   // Scan the raw stream: find the sync word, take 8 data bits and a parity bit, rehunt.
   function automatic void modelRun();
      logic [7:0] window;
      logic [7:0] d;
      event_t     e;
      int         i;
      expQ.delete();
      window = 8'h00;
      i = 0;
      while (i < streamQ.size()) begin
         window = {window[6:0], streamQ[i]};
         i++;
         if (window == 8'h7E) begin
            if (i + 9 > streamQ.size()) break;
            d = 8'h00;
            for (int k = 0; k < 8; k++) d = {d[6:0], streamQ[i+k]};
            e.data = d;
            e.ok   = ((^d) == streamQ[i+8]);
            expQ.push_back(e);
            window = 8'h00;
            i += 9;
         end
      end
   endfunction

   task automatic checkEvents(input string tag);
      int goodExp;
      int errExp;
      repeat (6) @(posedge sysclk);
      #1;
      modelRun();
      checkOutput({tag, ".count"}, 32'(obsQ.size()), 32'(expQ.size()));
      for (int k = checkedIdx; k < obsQ.size() && k < expQ.size(); k++) begin
         checkOutput({tag, ".data"}, 32'(obsQ[k].data), 32'(expQ[k].data));
         checkOutput({tag, ".ok"}, 32'(obsQ[k].ok), 32'(expQ[k].ok));
      end
      checkedIdx = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
      goodExp = 0;
      errExp  = 0;
      foreach (expQ[k]) begin
         if (expQ[k].ok) goodExp++;
         else errExp++;
      end
      if (goodExp > 255) goodExp = 255;
      if (errExp > 255) errExp = 255;
      checkOutput({tag, ".goodCnt"}, 32'(bus.good_cnt), 32'(goodExp));
      checkOutput({tag, ".errCnt"}, 32'(bus.err_cnt), 32'(errExp));
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      lockedCycles = 0;
      injected     = 0;
      checkedIdx   = 0;
      reset        = 1'b1;
      bus.bit_en   = 1'b0;
      bus.bit_in   = 1'b0;
      doReset();

      checkOutput("rst.dataOut", 32'(bus.data_out), 32'h0);
      checkOutput("rst.valid", 32'(bus.data_valid), 32'h0);
      checkOutput("rst.parErr", 32'(bus.parity_err), 32'h0);
      checkOutput("rst.locked", 32'(bus.locked), 32'h0);
      checkOutput("rst.goodCnt", 32'(bus.good_cnt), 32'h0);
      checkOutput("rst.errCnt", 32'(bus.err_cnt), 32'h0);

      // Basic good frame at a steady 4-cycle bit period.
      lockedCycles = 0;
      sendFrame(8'h69, 1'b0, 4, 4);
      checkEvents("t1");
      checkOutput("t1.dataOut", 32'(bus.data_out), 32'h69);
      checkOutput("t1.goodCnt1", 32'(bus.good_cnt), 32'd1);
      checkOutput("t1.lockedCycles", 32'(lockedCycles), 32'd37);
      checkOutput("t1.lockedLow", 32'(bus.locked), 32'd0);

      sendFrame(8'hEF, 1'b0, 4, 4);
      checkEvents("t2a");
      checkOutput("t2.dataOutGood", 32'(bus.data_out), 32'hEF);
      checkOutput("t2.goodCnt2", 32'(bus.good_cnt), 32'd2);
      sendFrame(8'hEF, 1'b1, 4, 4);
      checkEvents("t2b");
      checkOutput("t2.dataOutBad", 32'(bus.data_out), 32'hEF);
      checkOutput("t2.errCnt1", 32'(bus.err_cnt), 32'd1);
      checkOutput("t2.goodCntHeld", 32'(bus.good_cnt), 32'd2);

      // Noise without sync alignment, then a frame whose payload equals the sync word.
      sendByte(8'h3C, 3, 3);
      sendByte(8'hF0, 3, 3);
      checkEvents("t3noise");
      checkOutput("t3.noiseFrames", 32'(obsQ.size()), 32'd3);
      sendFrame(8'h7E, 1'b0, 3, 3);
      checkEvents("t3");
      checkOutput("t3.frames", 32'(obsQ.size()), 32'd4);
      checkOutput("t3.dataOut", 32'(bus.data_out), 32'h7E);

      // Reset in the middle of a payload.
      sendByte(8'h7E, 4, 4);
      applyStimulus(1'b0, 4);
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, 4);
      applyStimulus(1'b1, 4);
      checkOutput("t4.lockedPre", 32'(bus.locked), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t4.rstDataOut", 32'(bus.data_out), 32'h0);
      checkOutput("t4.rstLocked", 32'(bus.locked), 32'h0);
      checkOutput("t4.rstGoodCnt", 32'(bus.good_cnt), 32'h0);
      checkOutput("t4.rstValid", 32'(bus.data_valid), 32'h0);
      doReset();
      sendFrame(8'h55, 1'b0, 4, 4);
      checkEvents("t4");
      checkOutput("t4.dataOut", 32'(bus.data_out), 32'h55);
      checkOutput("t4.goodCnt", 32'(bus.good_cnt), 32'd1);

      // Good-frame counter saturation.
      doReset();
      for (int n = 0; n < 256; n++) begin
         sendFrame(8'($urandom), 1'b0, 2, 2);
      end
      checkEvents("t5");
      checkOutput("t5.frames", 32'(obsQ.size()), 32'd256);
      checkOutput("t5.goodSat", 32'(bus.good_cnt), 32'd255);

      // Random spacing and injected parity errors.
      doReset();
      injected = 0;
      for (int n = 0; n < 100; n++) begin
         bit flip;
         flip = ($urandom_range(3, 0) == 0);
         if (flip) injected++;
         sendFrame(8'($urandom), flip, 2, 20);
      end
      checkEvents("t6");
      checkOutput("t6.errInjected", 32'(bus.err_cnt), 32'(injected));
      checkOutput("t6.goodRest", 32'(bus.good_cnt), 32'(100 - injected));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
